// File: rtl/hwpf_nl_issuer.sv
// hwpf_nl_issuer: consumer side of the next-line prefetcher history queue.
// On a history update the queue is snapshotted and walked one entry per cycle.
// Each valid entry yields a candidate next-line address; candidates that wrap,
// duplicate a snapshot line or repeat the last issued line are dropped.
// Surviving candidates are issued over a valid/ready request port. The number
// of in-flight prefetches is bounded by MAX_OUTSTANDING.
//
// Optional build macro: HWPF_ISSUER_STATS_EN adds 32-bit wrapping counters
// stat_issued_o (request handshakes) and stat_filtered_o (valid entries dropped
// by the duplicate or last-line filters). These are cleared by rst_ni only.
//
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   flush_i                     synchronous flush of scan state
//   lock_i                      freeze engine
//   trigger_i                   history queue written this cycle
//   hist_addr_i/hist_valid_i    history queue contents (unpacked, storage order)
//   pf_req_valid_o/addr_o       prefetch request (line aligned)
//   pf_req_ready_i              downstream accepts request
//   pf_resp_valid_i             one outstanding prefetch completed
//   busy_o                      engine not idle
//
// state | meaning
// IDLE  | waiting for a history update
// SCAN  | evaluating snapshot entry idx
// ISSUE | request presented, waiting for ready
// WAIT  | in-flight limit reached, waiting for a response
module hwpf_nl_issuer #(
    parameter int QUEUE_DEPTH     = 8,
    parameter int ADDR_W          = 40,
    parameter int LINE_BYTES      = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              lock_i,
    input  logic              trigger_i,
    input  logic [ADDR_W-1:0] hist_addr_i [QUEUE_DEPTH],
    input  logic              hist_valid_i [QUEUE_DEPTH],
    output logic              pf_req_valid_o,
    output logic [ADDR_W-1:0] pf_req_addr_o,
    input  logic              pf_req_ready_i,
    input  logic              pf_resp_valid_i,
    output logic              busy_o
`ifdef HWPF_ISSUER_STATS_EN
    ,
    output logic [31:0]       stat_issued_o,
    output logic [31:0]       stat_filtered_o
`endif
);

    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(QUEUE_DEPTH);
    localparam int LINE_W = ADDR_W - OFF_W;
    localparam logic [3:0]       MAX_OS   = 4'(MAX_OUTSTANDING);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(QUEUE_DEPTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_ISSUE, ST_WAIT} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [3:0]          os_q, os_d;
    logic [LINE_W-1:0]   last_line_q;
    logic                last_valid_q;
    logic                rescan_q, rescan_d;
    logic [LINE_W-1:0]   snap_line_q [QUEUE_DEPTH];
    logic                snap_valid_q [QUEUE_DEPTH];

    logic                snap_load, snap_clr, req_load, filt_inc, advance;
    logic                hs, dup_hit, last_hit, carry, skip, skip_filt;
    logic [LINE_W-1:0]   cur_line, cand_line;
    logic                unused_low_bits;

    assign hs       = pf_req_valid_o & pf_req_ready_i;
    assign cur_line = snap_line_q[idx_q];
    assign {carry, cand_line} = {1'b0, cur_line} + (LINE_W + 1)'(1);
    assign last_hit = last_valid_q && (cand_line == last_line_q);

    always_comb begin
        dup_hit = 1'b0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (snap_valid_q[i] && (snap_line_q[i] == cand_line)) dup_hit = 1'b1;
        end
    end

    assign skip      = !snap_valid_q[idx_q] || carry || dup_hit || last_hit;
    assign skip_filt = snap_valid_q[idx_q] && !carry && (dup_hit || last_hit);

    // Simultaneous handshake and response cancel; a response at zero is dropped.
    always_comb begin
        os_d = os_q;
        if (hs && !pf_resp_valid_i)                          os_d = os_q + 4'd1;
        else if (!hs && pf_resp_valid_i && (os_q != 4'd0))   os_d = os_q - 4'd1;
    end

    // Offset bits of the history addresses never matter to a line address.
    always_comb begin
        unused_low_bits = 1'b0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            unused_low_bits = unused_low_bits ^ (^hist_addr_i[i][OFF_W-1:0]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rescan_d  = rescan_q;
        snap_load = 1'b0;
        snap_clr  = 1'b0;
        req_load  = 1'b0;
        filt_inc  = 1'b0;
        advance   = 1'b0;
        if (flush_i) begin
            state_d  = ST_IDLE;
            idx_d    = '0;
            rescan_d = 1'b0;
            snap_clr = 1'b1;
        end else if (!lock_i) begin
            if ((state_q != ST_IDLE) && trigger_i) rescan_d = 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (trigger_i) begin
                        snap_load = 1'b1;
                        idx_d     = '0;
                        state_d   = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (skip) begin
                        advance  = 1'b1;
                        filt_inc = skip_filt;
                    end else if (os_q < MAX_OS) begin
                        // Holding here when at the limit (possible after a
                        // flush) keeps the count bounded without losing the entry.
                        req_load = 1'b1;
                        state_d  = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (hs) begin
                        if (os_d == MAX_OS) state_d = ST_WAIT;
                        else                advance = 1'b1;
                    end else if (!pf_req_valid_o) begin
                        // Request was accepted while locked.
                        if (os_q >= MAX_OS) state_d = ST_WAIT;
                        else                advance = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (os_q < MAX_OS) advance = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
            if (advance) begin
                if (idx_q != IDX_LAST) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_SCAN;
                end else if (rescan_q || trigger_i) begin
                    snap_load = 1'b1;
                    idx_d     = '0;
                    rescan_d  = 1'b0;
                    state_d   = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end
    end

    always_comb begin
        busy_o = (state_q != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q          <= '0;
            rescan_q       <= 1'b0;
            os_q           <= '0;
            pf_req_valid_o <= 1'b0;
            pf_req_addr_o  <= '0;
            last_line_q    <= '0;
            last_valid_q   <= 1'b0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                snap_line_q[i]  <= '0;
                snap_valid_q[i] <= 1'b0;
            end
        end else begin
            idx_q    <= idx_d;
            rescan_q <= rescan_d;
            os_q     <= os_d;
            if (flush_i) begin
                pf_req_valid_o <= 1'b0;
            end else if (req_load) begin
                pf_req_valid_o <= 1'b1;
                pf_req_addr_o  <= {cand_line, {OFF_W{1'b0}}};
            end else if (hs) begin
                pf_req_valid_o <= 1'b0;
            end
            if (flush_i) begin
                last_valid_q <= 1'b0;
            end else if (hs) begin
                last_line_q  <= pf_req_addr_o[ADDR_W-1:OFF_W];
                last_valid_q <= 1'b1;
            end
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (snap_clr) begin
                    snap_valid_q[i] <= 1'b0;
                end else if (snap_load) begin
                    snap_line_q[i]  <= hist_addr_i[i][ADDR_W-1:OFF_W];
                    snap_valid_q[i] <= hist_valid_i[i];
                end
            end
        end
    end

`ifdef HWPF_ISSUER_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_issued_o   <= '0;
            stat_filtered_o <= '0;
        end else begin
            if (hs)       stat_issued_o   <= stat_issued_o + 32'd1;
            if (filt_inc) stat_filtered_o <= stat_filtered_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hwpf_nl_issuer.sv
// Testbench for hwpf_nl_issuer: directed scenarios plus randomized scans,
// with expected requests produced by a transaction-level model of the
// filtering rules.
module tb_hwpf_nl_issuer;

    localparam int QD    = 8;
    localparam int AW    = 40;
    localparam int OFF   = 6;
    localparam int LW    = AW - OFF;
    localparam int MAXOS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_ni, flush_i, lock_i, trigger_i, pf_req_ready_i, pf_resp_valid_i;
    logic [AW-1:0] hist_addr [QD];
    logic          hist_valid [QD];
    logic          pf_req_valid_o, busy_o;
    logic [AW-1:0] pf_req_addr_o;
`ifdef HWPF_ISSUER_STATS_EN
    logic [31:0]   stat_issued_o, stat_filtered_o;
`endif

    hwpf_nl_issuer #(
        .QUEUE_DEPTH(QD), .ADDR_W(AW), .LINE_BYTES(64), .MAX_OUTSTANDING(MAXOS)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .lock_i(lock_i),
        .trigger_i(trigger_i), .hist_addr_i(hist_addr), .hist_valid_i(hist_valid),
        .pf_req_valid_o(pf_req_valid_o), .pf_req_addr_o(pf_req_addr_o),
        .pf_req_ready_i(pf_req_ready_i), .pf_resp_valid_i(pf_resp_valid_i),
        .busy_o(busy_o)
`ifdef HWPF_ISSUER_STATS_EN
        , .stat_issued_o(stat_issued_o), .stat_filtered_o(stat_filtered_o)
`endif
    );

    int            n_checks = 0;
    int            n_errors = 0;
    logic [AW-1:0] exp_q [$];
    int            os_m, exp_iss, exp_filt, n_hs;
    logic [LW-1:0] m_last;
    logic          m_last_v;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Walk the currently driven history the way the spec describes, one entry
    // at a time, assuming each issued request is accepted before the next entry.
    task automatic model_scan();
        logic [LW-1:0] ln, cand;
        logic          dup;
        for (int i = 0; i < QD; i++) begin
            if (!hist_valid[i]) continue;
            ln = hist_addr[i][AW-1:OFF];
            if (&ln) continue;
            cand = ln + LW'(1);
            dup  = 1'b0;
            for (int j = 0; j < QD; j++)
                if (hist_valid[j] && hist_addr[j][AW-1:OFF] == cand) dup = 1'b1;
            if (dup || (m_last_v && m_last == cand)) begin
                exp_filt++;
                continue;
            end
            exp_q.push_back({cand, 6'b0});
            m_last   = cand;
            m_last_v = 1'b1;
            exp_iss++;
        end
    endtask

    task automatic check_stats();
`ifdef HWPF_ISSUER_STATS_EN
        check("stat_issued", stat_issued_o, exp_iss);
        check("stat_filtered", stat_filtered_o, exp_filt);
`endif
    endtask

    // One clock: record the handshake/response seen at the edge, then check.
    task automatic do_cycle();
        logic          v0, r0, f0, rs0, hs;
        logic [AW-1:0] a0;
        int            os0;
        v0 = pf_req_valid_o; r0 = pf_req_ready_i; f0 = flush_i;
        rs0 = pf_resp_valid_i; a0 = pf_req_addr_o; os0 = os_m;
        hs = v0 && r0;
        @(posedge clk); #1;
        if (hs) begin
            n_hs++;
            check("limit", os0 < MAXOS, 1);
            check("req_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("req_addr", a0, exp_q.pop_front());
            if (!rs0) os_m++;
        end else if (rs0 && os_m > 0) begin
            os_m--;
        end
        if (v0 && !r0 && !f0 && rst_ni) begin
            check("hold_valid", pf_req_valid_o, 1);
            check("hold_addr", pf_req_addr_o, a0);
        end
    endtask

    task automatic trigger_pulse();
        trigger_i = 1'b1;
        do_cycle();
        trigger_i = 1'b0;
    endtask

    task automatic run_scan(input int rdy_pct, input int rsp_pct);
        int cyc = 0;
        while ((busy_o || pf_req_valid_o) && cyc < 3000) begin
            pf_req_ready_i  = ($urandom_range(99) < rdy_pct);
            pf_resp_valid_i = (os_m > 0) && ($urandom_range(99) < rsp_pct);
            do_cycle();
            cyc++;
        end
        pf_req_ready_i  = 1'b0;
        pf_resp_valid_i = 1'b0;
        check("scan_done", busy_o, 0);
        check("all_issued", exp_q.size(), 0);
        check_stats();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; flush_i = 1'b0; lock_i = 1'b0; trigger_i = 1'b0;
        pf_req_ready_i = 1'b0; pf_resp_valid_i = 1'b0;
        for (int i = 0; i < QD; i++) begin
            hist_addr[i]  = '0;
            hist_valid[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", pf_req_valid_o, 0);
        check("rst_addr", pf_req_addr_o, 0);
        check("rst_busy", busy_o, 0);
        exp_q.delete();
        os_m = 0; exp_iss = 0; exp_filt = 0; n_hs = 0;
        m_last = '0; m_last_v = 1'b0;
        check_stats();
        rst_ni = 1'b1;
    endtask

    initial begin
        int            cnt;
        logic [LW-1:0] ln;

        // Single entry, first-request latency
        do_reset();
        hist_addr[0] = 40'h1000; hist_valid[0] = 1'b1;
        model_scan();
        trigger_pulse();
        check("t1_busy", busy_o, 1);
        check("t1_valid_t1", pf_req_valid_o, 0);
        do_cycle();
        check("t1_valid_t2", pf_req_valid_o, 1);
        check("t1_addr_t2", pf_req_addr_o, 40'h1040);
        run_scan(100, 50);
        check("t1_nreq", n_hs, 1);

        // Duplicate filter
        do_reset();
        hist_addr[0] = 40'h1000; hist_valid[0] = 1'b1;
        hist_addr[1] = 40'h1040; hist_valid[1] = 1'b1;
        model_scan();
        trigger_pulse();
        run_scan(100, 50);
        check("dup_nreq", n_hs, 1);

        // Outstanding limit and resume on response
        do_reset();
        for (int i = 0; i < 4; i++) begin
            hist_addr[i]  = AW'(i) << 12;
            hist_valid[i] = 1'b1;
        end
        model_scan();
        pf_req_ready_i = 1'b1;
        trigger_pulse();
        repeat (12) do_cycle();
        check("lim_nreq", n_hs, 2);
        check("lim_valid", pf_req_valid_o, 0);
        check("lim_busy", busy_o, 1);
        pf_resp_valid_i = 1'b1;
        do_cycle();
        pf_resp_valid_i = 1'b0;
        for (int k = 0; k < 8 && n_hs < 3; k++) do_cycle();
        check("lim_resume", n_hs, 3);
        run_scan(100, 50);
        check("lim_total", n_hs, 4);

        // Wrap filter: full scan with no request
        do_reset();
        hist_addr[0] = 40'hFF_FFFF_FFC0; hist_valid[0] = 1'b1;
        model_scan();
        trigger_pulse();
        cnt = 0;
        for (int k = 0; k < 20 && busy_o; k++) begin
            cnt++;
            do_cycle();
        end
        check("wrap_scan_cycles", cnt, QD);
        check("wrap_nreq", n_hs, 0);
        check_stats();

        // Rescan on trigger during ISSUE; last line not reissued
        do_reset();
        hist_addr[0] = 40'h1000; hist_valid[0] = 1'b1;
        model_scan();
        trigger_pulse();
        do_cycle();
        check("rs_valid", pf_req_valid_o, 1);
        hist_addr[1] = 40'h5000; hist_valid[1] = 1'b1;
        model_scan();
        trigger_pulse();
        run_scan(100, 50);
        check("rs_nreq", n_hs, 2);

        // Lock holds request, flush drops it and keeps outstanding count
        do_reset();
        for (int i = 0; i < 4; i++) begin
            hist_addr[i]  = AW'(i) << 12;
            hist_valid[i] = 1'b1;
        end
        exp_q.push_back(40'h40); exp_iss = 1;
        trigger_pulse();
        for (int k = 0; k < 5 && !pf_req_valid_o; k++) do_cycle();
        lock_i = 1'b1;
        repeat (4) begin
            do_cycle();
            check("lock_valid", pf_req_valid_o, 1);
            check("lock_addr", pf_req_addr_o, 40'h40);
        end
        pf_req_ready_i = 1'b1;
        do_cycle();
        pf_req_ready_i = 1'b0;
        check("lock_hs", n_hs, 1);
        do_cycle();
        check("lock_frozen_valid", pf_req_valid_o, 0);
        check("lock_frozen_busy", busy_o, 1);
        lock_i = 1'b0;
        for (int k = 0; k < 6 && !pf_req_valid_o; k++) do_cycle();
        check("unlock_valid", pf_req_valid_o, 1);
        check("unlock_addr", pf_req_addr_o, 40'h1040);
        flush_i = 1'b1;
        do_cycle();
        flush_i = 1'b0;
        check("flush_valid", pf_req_valid_o, 0);
        check("flush_busy", busy_o, 0);
        m_last_v = 1'b0;
        for (int i = 0; i < QD; i++) hist_valid[i] = 1'b0;
        hist_addr[0] = 40'h8000; hist_valid[0] = 1'b1;
        hist_addr[1] = 40'h9000; hist_valid[1] = 1'b1;
        model_scan();
        pf_req_ready_i = 1'b1;
        trigger_pulse();
        repeat (10) do_cycle();
        check("flush_os_kept", n_hs, 2);
        check("flush_wait_valid", pf_req_valid_o, 0);
        run_scan(100, 50);
        check("flush_total", n_hs, 3);

        // Asynchronous reset mid-request
        do_reset();
        hist_addr[0] = 40'h1000; hist_valid[0] = 1'b1;
        trigger_pulse();
        do_cycle();
        #3;
        rst_ni = 1'b0;
        #1;
        check("arst_valid", pf_req_valid_o, 0);
        check("arst_addr", pf_req_addr_o, 0);
        check("arst_busy", busy_o, 0);

        // Randomized scans from a small line pool to provoke filter hits
        do_reset();
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < QD; i++) begin
                ln = ($urandom_range(7) == 0) ? '1 : LW'($urandom_range(20));
                hist_addr[i]  = {ln, 6'($urandom)};
                hist_valid[i] = ($urandom_range(9) < 7);
            end
            model_scan();
            trigger_pulse();
            run_scan(70, 30);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
